// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with per-frame bit order and valid/ready handshakes.
// Optional trailing even-parity bit when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_dir,
    output logic             s_valid,
    output logic             s_data,
    input  logic             s_ready,
    output logic             frame_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    function automatic logic parity_even(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   shreg_r, shreg_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               dir_r, dir_s;
    logic               xfer_s;
    logic               s_data_s;
    logic               frame_done_s;
    logic               load_ready_r, s_valid_r, s_data_r, frame_done_r, busy_r;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic               par_r, par_s;
`endif

    assign xfer_s = s_valid_r & s_ready;

    // Next-state, datapath update and the value each registered output takes next cycle.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        cnt_s    = cnt_r;
        dir_s    = dir_r;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_s    = par_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (load_valid) begin
                    shreg_s = load_data;
                    dir_s   = load_dir;
                    cnt_s   = CNT_LAST;
`ifdef PISO_SERIALIZER_PARITY_EN
                    par_s   = parity_even(load_data);
`endif
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (xfer_s) begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        shreg_s = dir_r ? {1'b0, shreg_r[WIDTH-1:1]}
                                        : {shreg_r[WIDTH-2:0], 1'b0};
                        cnt_s   = cnt_r - CNT_W'(1);
                    end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_IDLE;
`endif
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (xfer_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Serial bit is looked up from the post-update register so it is ready the cycle after.
        case (state_s)
            ST_SHIFT:  s_data_s = dir_s ? shreg_s[0] : shreg_s[WIDTH-1];
`ifdef PISO_SERIALIZER_PARITY_EN
            ST_PARITY: s_data_s = par_s;
`endif
            default:   s_data_s = 1'b0;
        endcase

        if ((state_r != ST_IDLE) && (state_s == ST_IDLE)) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // State, datapath and registered outputs; synchronous reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            dir_r        <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_r        <= 1'b0;
`endif
            load_ready_r <= 1'b1;
            s_valid_r    <= 1'b0;
            s_data_r     <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            cnt_r        <= cnt_s;
            dir_r        <= dir_s;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_r        <= par_s;
`endif
            load_ready_r <= (state_s == ST_IDLE);
            s_valid_r    <= (state_s != ST_IDLE);
            s_data_r     <= s_data_s;
            frame_done_r <= frame_done_s;
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign load_ready = load_ready_r;
    assign s_valid    = s_valid_r;
    assign s_data     = s_data_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed cases plus randomized frames and stalls,
// checked against a bit-list reference model built from the loaded word.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         load_dir;
    logic         s_valid;
    logic         s_data;
    logic         s_ready;
    logic         frame_done;
    logic         busy;

    int total  = 0;
    int passed = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dir   (load_dir),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: the list of bits a frame must carry, in transfer order.
    function automatic void model_bits(input logic [W-1:0] word, input logic dir, output bit q[$]);
        q = {};
        for (int i = 0; i < W; i++) q.push_back(dir ? word[i] : word[W-1-i]);
`ifdef PISO_SERIALIZER_PARITY_EN
        q.push_back(^word);
`endif
    endfunction

    // Loads a word and drains the frame. stall_at/stall_len insert a directed stall before
    // bit stall_at; pct is the random stall probability. hold keeps load_valid high with next_word.
    task automatic frame(input string nm, input logic [W-1:0] word, input logic dir,
                         input int stall_at, input int stall_len, input int pct,
                         input bit hold, input logic [W-1:0] next_word);
        bit q[$];
        int k, cycles, stalls, dstall, guard;
        model_bits(word, dir, q);
        guard = 0;
        while (load_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check({nm, "_load_ready"}, load_ready, 1'b1);
        load_valid = 1'b1;
        load_data  = word;
        load_dir   = dir;
        s_ready    = 1'b0;
        step();
        if (hold) begin
            load_data = next_word;
        end else begin
            load_valid = 1'b0;
            load_data  = $urandom;
        end
        k = 0; cycles = 0; stalls = 0; dstall = 0;
        while (k < q.size() && cycles < 200) begin
            check({nm, "_s_valid"}, s_valid, 1'b1);
            check({nm, "_s_data"}, s_data, q[k]);
            if (k == 0) begin
                check({nm, "_busy"}, busy, 1'b1);
                check({nm, "_ready_low"}, load_ready, 1'b0);
            end
            if (frame_done !== 1'b0) check({nm, "_early_done"}, frame_done, 1'b0);
            if (k == stall_at && dstall < stall_len) begin
                s_ready = 1'b0;
                dstall++;
            end else begin
                s_ready = ($urandom_range(99) >= pct);
            end
            if (!s_ready) stalls++;
            step();
            cycles++;
            if (s_ready) k++;
        end
        s_ready = 1'b0;
        check({nm, "_bits_sent"}, k, q.size());
        check({nm, "_frame_cycles"}, cycles, q.size() + stalls);
        check({nm, "_done_pulse"}, frame_done, 1'b1);
        check({nm, "_done_ready"}, load_ready, 1'b1);
        check({nm, "_gap_valid"}, s_valid, 1'b0);
        check({nm, "_gap_data"}, s_data, 1'b0);
        check({nm, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rw;
        logic [W-1:0] seq;
        rst = 1'b1; load_valid = 1'b0; load_data = '0; load_dir = 1'b0; s_ready = 1'b0;
        step();
        step();
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_s_valid", s_valid, 1'b0);
        check("rst_s_data", s_data, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        step();

        // Directed cases.
        frame("msb_b4", 8'hB4, 1'b0, -1, 0, 0, 1'b0, 8'h00);
        step();
        check("done_single", frame_done, 1'b0);
        frame("lsb_b4", 8'hB4, 1'b1, -1, 0, 0, 1'b0, 8'h00);
        step();
        check("done_single2", frame_done, 1'b0);
        frame("stall_b4", 8'hB4, 1'b0, 2, 3, 0, 1'b0, 8'h00);

        // Reset after bit 4 aborts the frame.
        step();
        load_valid = 1'b1; load_data = 8'hB4; load_dir = 1'b0;
        step();
        load_valid = 1'b0;
        s_ready = 1'b1;
        seq = 8'hB4;
        for (int i = 0; i < 4; i++) begin
            check("abort_pre_bit", s_data, seq[W-1-i]);
            step();
        end
        s_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_s_valid", s_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", load_ready, 1'b1);
        check("abort_no_done", frame_done, 1'b0);
        step();
        check("abort_no_done2", frame_done, 1'b0);
        frame("post_abort_0f", 8'h0F, 1'b0, -1, 0, 0, 1'b0, 8'h00);

        // Back-to-back with load_valid held.
        step();
        frame("b2b_55", 8'h55, 1'b0, -1, 0, 0, 1'b1, 8'hAA);
        frame("b2b_aa", 8'hAA, 1'b0, -1, 0, 0, 1'b0, 8'h00);

`ifdef PISO_SERIALIZER_PARITY_EN
        step();
        frame("par_07", 8'h07, 1'b0, -1, 0, 0, 1'b0, 8'h00);
`endif

        // Randomized frames with random stalls and bit order.
        for (int n = 0; n < 24; n++) begin
            rw = $urandom;
            if ($urandom_range(1) == 1) step();
            frame("rand", rw, 1'(($urandom_range(1))), $urandom_range(W-1), $urandom_range(3),
                  30, 1'b0, 8'h00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
